flag_stack_file: RTL and testbench
==================================

// Module: flag_stack_file
// PURPOSE
//  Parametrised condition-flag register for the pipelined datapath.
//  - Per-flag write mask; each flag updates independently.
//  - LIFO snapshot stack (DEPTH entries) saves/restores the whole flag vector around exceptions/calls.
//  - Sits between the EX-stage ALU flag outputs and branch-resolve logic; replaces the fixed 4-flag register.
// PARAMETERS
//  NFLAGS  4  flag vector width; bit0=zero, bit1=negative, bit2=overflow, bit3=carryout, higher bits user-defined
//  DEPTH   4  snapshot stack entries (>=1)
// PORTS
//  clk       in   1                    single clock, rising edge
//  reset     in   1                    synchronous, active-high
//  flag_we   in   NFLAGS               per-flag write enable
//  flags_in  in   NFLAGS               new flag values from ALU
//  push      in   1                    save live flags onto stack
//  pop       in   1                    restore live flags from stack top
//  err_clr   in   1                    clear sticky error
//  flags     out  NFLAGS               current flag vector
//  count     out  $clog2(DEPTH+1)      occupied stack entries
//  empty     out  1                    count==0
//  full      out  1                    count==DEPTH
//  err       out  1                    sticky misuse indicator
// BEHAVIOUR
//  - Reset (sync, dominates all inputs): live flags=0, stack entries=0, count=0, empty=1, full=0, err=0.
//  - Write: live[i] <= flags_in[i] at the edge when flag_we[i]=1; unmasked bits hold.
//  - Push (legal when !full, !pop): stack[count] <= live value BEFORE this cycle's write; count+1.
//    A same-cycle flag_we still updates live.
//  - Pop (legal when !empty, !push): live <= stack[count-1]; count-1.
//    Pop has priority: same-cycle flag_we ignored entirely.
//  - Illegal cases set err<=1 with no state change for the offending op:
//    - push&&pop in one cycle: neither happens; flag_we is still applied.
//    - push when full.
//    - pop when empty.
//  - err is sticky; cleared by err_clr at the edge.
//    If err_clr and a new illegal op coincide, err stays 1 (set wins).
//  - count, empty, full are registered; they reflect the state after the edge, no wrap-around.
//  - No handshake/stall: every op completes in the cycle presented.
// CONFIGURATION
//  FLAG_STACK_BYPASS_EN defined:
//   - flags = combinational next-state of live register (write/pop visible same cycle, 0-cycle latency).
//   - Reset still forces flags=0 in the reset cycle.
//  FLAG_STACK_BYPASS_EN undefined:
//   - flags = live register output; 1-cycle latency after write or pop.
//  Stack, count and err timing are identical in both builds.
// TESTING
//  1 reset, then flag_we=4'b0101 flags_in=4'b1111
//    -> flags=4'b0101 (next cycle; same cycle with bypass).
//  2 live=4'b0011, push with flag_we=4'hF flags_in=4'b1000
//    -> stack[0]=4'b0011, count=1, flags=4'b1000.
//    Then pop with flag_we=4'hF flags_in=4'b0110
//    -> flags=4'b0011, count=0, empty=1.
//  3 DEPTH=4: push 5 times with live=4'h1,4'h2,4'h3,4'h4,4'h5
//    -> full=1 after 4th push, 5th ignored, err=1.
//    Then 4 pops -> flags 4'h4,4'h3,4'h2,4'h1.
//  4 pop on empty -> flags unchanged, count=0, err=1.
//    err_clr -> err=0 next cycle.
//  5 push&&pop together with count=2, flag_we=4'b0001 flags_in=4'b0001
//    -> count stays 2, err=1, flags[0]=1.
//  6 count=3, flags=4'hA; assert reset for one cycle with push=1
//    -> flags=0, count=0, empty=1, err=0; the push is lost.

Source files
------------

// File: rtl/flag_stack_file.sv
// flag_stack_file: condition-flag register with per-flag write mask and a
// LIFO snapshot stack that saves/restores the whole flag vector.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   flag_we          per-flag write enable
//   flags_in         new flag values from the ALU
//   push / pop       save live flags / restore live flags from stack top
//   err_clr          clear the sticky misuse indicator
//   flags            current flag vector
//   count            occupied stack entries
//   empty / full     count==0 / count==DEPTH (registered)
//   err              sticky misuse indicator
//
// Build option: define FLAG_STACK_BYPASS_EN to drive flags from the
// next-state of the live register (0-cycle latency) instead of the register.
module flag_stack_file #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NFLAGS-1:0] flag_we,
    input  logic [NFLAGS-1:0] flags_in,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic [NFLAGS-1:0] flags,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              err
);

    logic [NFLAGS-1:0] live_q, live_d;
    logic [NFLAGS-1:0] stack_q [DEPTH];
    logic [NFLAGS-1:0] stack_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic              do_push;
    logic              do_pop;
    logic              illegal;
    logic [NFLAGS-1:0] top;

    always_comb begin
        do_push = push && !pop && !full_q;
        do_pop  = pop && !push && !empty_q;
        illegal = (push && pop)
                || (push && !pop && full_q)
                || (pop && !push && empty_q);

        // Stack top selected by compare so count never indexes out of range.
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) begin
                top = stack_q[i];
            end
        end

        live_d  = live_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = stack_q[i];
        end

        if (do_pop) begin
            // A legal pop overrides any same-cycle flag write.
            live_d  = top;
            count_d = count_q - CW'(1);
        end else begin
            for (int i = 0; i < NFLAGS; i++) begin
                if (flag_we[i]) begin
                    live_d[i] = flags_in[i];
                end
            end
        end

        if (do_push) begin
            // Snapshot is the live value from before this cycle's write.
            for (int i = 0; i < DEPTH; i++) begin
                if (count_q == CW'(i)) begin
                    stack_d[i] = live_q;
                end
            end
            count_d = count_q + CW'(1);
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        // A new misuse in the same cycle as err_clr keeps err set.
        err_d   = illegal || (err_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            live_q  <= live_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

`ifdef FLAG_STACK_BYPASS_EN
    assign flags = reset ? '0 : live_d;
`else
    assign flags = live_q;
`endif

    assign count = count_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign err   = err_q;

endmodule

// File: tb/tb_flag_stack_file.sv
// tb_flag_stack_file: directed vector table plus randomized run checked
// against a queue-based reference model (default, non-bypass build).
module tb_flag_stack_file;

    localparam int NF = 4;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] flag_we;
    logic [NF-1:0] flags_in;
    logic          push;
    logic          pop;
    logic          err_clr;
    logic [NF-1:0] flags;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          err;

    int n_vec = 0;
    int n_bad = 0;

    flag_stack_file #(.NFLAGS(NF), .DEPTH(DP)) dut (
        .clk      (clk),
        .reset    (reset),
        .flag_we  (flag_we),
        .flags_in (flags_in),
        .push     (push),
        .pop      (pop),
        .err_clr  (err_clr),
        .flags    (flags),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NF-1:0] we;
        logic [NF-1:0] fin;
        logic          psh;
        logic          pp;
        logic          clr;
        logic [NF-1:0] ef;
        logic [CW-1:0] ec;
        logic          ee;
        logic          efu;
        logic          eer;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [NF-1:0] w,
                                logic [NF-1:0] fi, logic ps, logic po,
                                logic cl, logic [NF-1:0] f,
                                logic [CW-1:0] c, logic e, logic fu,
                                logic er);
        vec_t v;
        v.rst = r; v.we = w; v.fin = fi; v.psh = ps; v.pp = po;
        v.clr = cl; v.ef = f; v.ec = c; v.ee = e; v.efu = fu; v.eer = er;
        return v;
    endfunction

    task automatic drive(logic r, logic [NF-1:0] w, logic [NF-1:0] fi,
                         logic ps, logic po, logic cl);
        @(negedge clk);
        reset = r; flag_we = w; flags_in = fi;
        push = ps; pop = po; err_clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [NF-1:0] f, logic [CW-1:0] c,
                         logic e, logic fu, logic er);
        n_vec++;
        if (flags !== f || count !== c || empty !== e
            || full !== fu || err !== er) begin
            n_bad++;
            $display("FAIL %s: got f=%h c=%0d e=%b fu=%b err=%b want f=%h c=%0d e=%b fu=%b err=%b",
                     nm, flags, count, empty, full, err, f, c, e, fu, er);
        end
    endtask

    // Reference model state
    logic [NF-1:0] m_live;
    logic [NF-1:0] m_stk[$];
    logic          m_err;

    task automatic model_step(logic r, logic [NF-1:0] w,
                              logic [NF-1:0] fi, logic ps, logic po,
                              logic cl);
        bit bad;
        if (r) begin
            m_live = '0;
            m_stk.delete();
            m_err = 1'b0;
            return;
        end
        bad = (ps && po) || (ps && !po && m_stk.size() == DP)
              || (po && !ps && m_stk.size() == 0);
        if (po && !ps && m_stk.size() > 0) begin
            m_live = m_stk.pop_back();
        end else begin
            if (ps && !po && m_stk.size() < DP) m_stk.push_back(m_live);
            m_live = (m_live & ~w) | (fi & w);
        end
        m_err = bad ? 1'b1 : (cl ? 1'b0 : m_err);
    endtask

    initial begin
        reset = 1'b1; flag_we = '0; flags_in = '0;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;

        // rst, we, fin, push, pop, clr -> flags, count, empty, full, err
        tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 4'hF, 0, 0, 0, 4'b0101, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'b0011, 0, 0, 0, 4'b0011, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'b1000, 1, 0, 0, 4'b1000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'b0110, 0, 1, 0, 4'b0011, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'h1, 0, 0, 0, 4'h1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'h2, 1, 0, 0, 4'h2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'h3, 1, 0, 0, 4'h3, 2, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'h4, 1, 0, 0, 4'h4, 3, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'h5, 1, 0, 0, 4'h5, 4, 0, 1, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 4'h5, 4, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 4'h4, 3, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 4'h3, 2, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 4'h2, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 4'h1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 4'h1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 4'h1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 4'h1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 1, 4'h1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 4'h1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 4'h1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'hA, 1, 0, 0, 4'hA, 2, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 1, 1, 0, 4'hB, 2, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 4'hB, 2, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].fin,
                  tbl[i].psh, tbl[i].pp, tbl[i].clr);
            check($sformatf("tbl%0d", i), tbl[i].ef, tbl[i].ec,
                  tbl[i].ee, tbl[i].efu, tbl[i].eer);
        end

        // count=3, flags=A, err set; reset with push wipes everything
        drive(0, 4'h0, 4'h0, 1, 0, 0);
        check("seq_push3", 4'hB, 3, 0, 0, 0);
        drive(0, 4'hF, 4'hA, 1, 1, 0);
        check("seq_setA", 4'hA, 3, 0, 0, 1);
        drive(1, 4'hF, 4'h7, 1, 0, 0);
        check("seq_rst_push", 4'h0, 0, 1, 0, 0);
        drive(0, 4'h0, 4'h0, 0, 1, 0);
        check("seq_pop_after_rst", 4'h0, 0, 1, 0, 1);

        // Randomized run against the reference model
        drive(1, 4'h0, 4'h0, 0, 0, 0);
        model_step(1, '0, '0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic          r, ps, po, cl;
            logic [NF-1:0] w, fi;
            r  = ($urandom_range(0, 40) == 0);
            ps = ($urandom_range(0, 2) == 0);
            po = ($urandom_range(0, 2) == 0);
            cl = ($urandom_range(0, 5) == 0);
            w  = NF'($urandom);
            fi = NF'($urandom);
            drive(r, w, fi, ps, po, cl);
            model_step(r, w, fi, ps, po, cl);
            check($sformatf("rnd%0d", i), m_live, CW'(m_stk.size()),
                  m_stk.size() == 0, m_stk.size() == DP, m_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
